// File: rtl/blob_perimeter_tracker.sv
// Single-object mask statistics: area, bounding box and perimeter of all
// foreground pixels in one raster-ordered binary frame. Each incoming pixel
// completes the 4-neighbourhood of the pixel one row above it. A flush pass
// after frame_done_in evaluates the last row against an implicit background
// row below it.
module blob_perimeter_tracker #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 180,
   parameter int PERIM_MODE = 0,
   localparam int AREA_W    = $clog2(WIDTH*HEIGHT) + 1,
   localparam int PERIM_W   = $clog2(4*WIDTH*HEIGHT) + 1
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [10:0]        x_in,
   input  logic [9:0]         y_in,
   input  logic               mask_in,
   input  logic               pixel_valid_in,
   input  logic               frame_done_in,
   output logic [PERIM_W-1:0] perimeter,
   output logic [AREA_W-1:0]  area,
   output logic [10:0]        x_min,
   output logic [10:0]        x_max,
   output logic [9:0]         y_min,
   output logic [9:0]         y_max,
   output logic               busy_out,
   output logic               valid_out
);

   localparam int            XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [10:0]   X_LIM  = 11'(WIDTH);
   localparam logic [9:0]    Y_LIM  = 10'(HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   buf0_q, buf1_q;
   logic               lreg_q;
   logic [XW-1:0]      fx_q;
   logic [AREA_W-1:0]  area_q, area_d, area_base;
   logic [PERIM_W-1:0] perim_q, perim_d, perim_base;
   logic [10:0]        xmin_q, xmin_d, xmax_q, xmax_d;
   logic [9:0]         ymin_q, ymin_d, ymax_q, ymax_d;

   logic               in_frame, start, accept, last_flush;
   logic [XW-1:0]      xi, ci, ri;
   logic               c_ctr, c_up, c_dn, c_lf, c_rt, eval;
   logic [2:0]         inc;

   // Perimeter contribution of one centre pixel given its 4-neighbourhood.
   function automatic logic [2:0] perim_inc(input logic c, input logic u, input logic d,
                                            input logic l, input logic r);
      if (!c)
         return 3'd0;
      if (PERIM_MODE == 0)
         return {2'b00, ~(u & d & l & r)};
      return {2'b00, ~u} + {2'b00, ~d} + {2'b00, ~l} + {2'b00, ~r};
   endfunction

   assign xi         = x_in[XW-1:0];
   assign in_frame   = pixel_valid_in && (x_in < X_LIM) && (y_in < Y_LIM);
   assign start      = in_frame && (x_in == 11'd0) && (y_in == 10'd0) &&
                       ((state_q == IDLE) || (state_q == ACCUM));
   assign accept     = in_frame && ((state_q == ACCUM) || start);
   assign last_flush = (state_q == FLUSH) && (fx_q == X_LAST);
   assign busy_out   = (state_q == FLUSH);

   // Frame sequencing state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state: start on pixel (0,0), flush on frame end, one result cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)         state_d = ACCUM;
         ACCUM:   if (frame_done_in) state_d = FLUSH;
         FLUSH:   if (last_flush)    state_d = DONE;
         DONE:                       state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Neighbourhood of the centre being evaluated: (x, y-1) while streaming,
   // (fx, HEIGHT-1) with a background row below while flushing.
   always_comb begin
      ci   = xi;
      c_up = 1'b0;
      c_dn = 1'b0;
      eval = 1'b0;
      if (state_q == FLUSH) begin
         ci   = fx_q;
         c_up = buf0_q[fx_q];
         eval = 1'b1;
      end else begin
         c_up = (y_in >= 10'd2) ? buf0_q[xi] : 1'b0;
         c_dn = mask_in;
         eval = accept && (y_in != 10'd0);
      end
      ri    = ci + XW'(1);
      c_ctr = buf1_q[ci];
      c_lf  = (ci != '0) ? lreg_q : 1'b0;
      c_rt  = (ci != X_LAST) ? buf1_q[ri] : 1'b0;
      inc   = eval ? perim_inc(c_ctr, c_up, c_dn, c_lf, c_rt) : 3'd0;
   end

   // Accumulator next-state; a start pixel clears before it is counted.
   always_comb begin
      area_base  = start ? '0 : area_q;
      perim_base = start ? '0 : perim_q;
      area_d     = area_base;
      perim_d    = perim_base;
      xmin_d     = xmin_q;
      xmax_d     = xmax_q;
      ymin_d     = ymin_q;
      ymax_d     = ymax_q;
      if (accept) begin
         perim_d = perim_base + PERIM_W'(inc);
         if (mask_in) begin
            area_d = area_base + AREA_W'(1);
            if (area_base == '0) begin
               xmin_d = x_in;
               xmax_d = x_in;
               ymin_d = y_in;
               ymax_d = y_in;
            end else begin
               if (x_in < xmin_q) xmin_d = x_in;
               if (x_in > xmax_q) xmax_d = x_in;
               if (y_in < ymin_q) ymin_d = y_in;
               if (y_in > ymax_q) ymax_d = y_in;
            end
         end
      end else if (state_q == FLUSH) begin
         perim_d = perim_q + PERIM_W'(inc);
      end
   end

   // Accumulators, flush column counter and registered results.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         area_q    <= '0;
         perim_q   <= '0;
         xmin_q    <= '0;
         xmax_q    <= '0;
         ymin_q    <= '0;
         ymax_q    <= '0;
         fx_q      <= '0;
         perimeter <= '0;
         area      <= '0;
         x_min     <= '0;
         x_max     <= '0;
         y_min     <= '0;
         y_max     <= '0;
         valid_out <= 1'b0;
      end else begin
         area_q    <= area_d;
         perim_q   <= perim_d;
         xmin_q    <= xmin_d;
         xmax_q    <= xmax_d;
         ymin_q    <= ymin_d;
         ymax_q    <= ymax_d;
         fx_q      <= (state_q == FLUSH) ? fx_q + XW'(1) : '0;
         valid_out <= 1'b0;
         if (last_flush) begin
            valid_out <= 1'b1;
            area      <= area_q;
            if (area_q == '0) begin
               perimeter <= '0;
               x_min     <= '0;
               x_max     <= '0;
               y_min     <= '0;
               y_max     <= '0;
            end else begin
               perimeter <= perim_d;
               x_min     <= xmin_q;
               x_max     <= xmax_q;
               y_min     <= ymin_q;
               y_max     <= ymax_q;
            end
         end
      end
   end

   // Two-row line buffer plus the pre-overwrite left neighbour.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         buf0_q[xi] <= buf1_q[xi];
         buf1_q[xi] <= mask_in;
         lreg_q     <= buf1_q[xi];
      end else if (state_q == FLUSH) begin
         lreg_q     <= buf1_q[fx_q];
      end
   end

endmodule

// File: tb/tb_blob_perimeter_tracker.sv
// Bench for blob_perimeter_tracker: a small 8x4 pair and a 24x26 pair of
// instances (perimeter modes 0 and 1), each pair on its own valid/frame_done.
module tb_blob_perimeter_tracker;

   localparam int SW  = 8;
   localparam int SH  = 4;
   localparam int BW  = 24;
   localparam int BH  = 26;
   localparam int SAW = $clog2(SW*SH) + 1;
   localparam int SPW = $clog2(4*SW*SH) + 1;
   localparam int BAW = $clog2(BW*BH) + 1;
   localparam int BPW = $clog2(4*BW*BH) + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] x;
   logic [9:0]  y;
   logic        mask;
   logic [1:0]  vld, fd;

   logic [63:0] o_perim[4], o_area[4], o_x0[4], o_x1[4], o_y0[4], o_y1[4];
   logic        o_busy[4], o_valid[4];

   always #5 clk = ~clk;

   for (genvar m = 0; m < 2; m++) begin : g_s
      logic [SPW-1:0] p;
      logic [SAW-1:0] a;
      logic [10:0]    xa, xb;
      logic [9:0]     ya, yb;
      logic           bz, vo;
      blob_perimeter_tracker #(.WIDTH(SW), .HEIGHT(SH), .PERIM_MODE(m)) u_dut (
         .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .mask_in(mask),
         .pixel_valid_in(vld[0]), .frame_done_in(fd[0]),
         .perimeter(p), .area(a), .x_min(xa), .x_max(xb), .y_min(ya), .y_max(yb),
         .busy_out(bz), .valid_out(vo));
      assign o_perim[m] = 64'(p);
      assign o_area[m]  = 64'(a);
      assign o_x0[m]    = 64'(xa);
      assign o_x1[m]    = 64'(xb);
      assign o_y0[m]    = 64'(ya);
      assign o_y1[m]    = 64'(yb);
      assign o_busy[m]  = bz;
      assign o_valid[m] = vo;
   end

   for (genvar m = 0; m < 2; m++) begin : g_b
      logic [BPW-1:0] p;
      logic [BAW-1:0] a;
      logic [10:0]    xa, xb;
      logic [9:0]     ya, yb;
      logic           bz, vo;
      blob_perimeter_tracker #(.WIDTH(BW), .HEIGHT(BH), .PERIM_MODE(m)) u_dut (
         .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .mask_in(mask),
         .pixel_valid_in(vld[1]), .frame_done_in(fd[1]),
         .perimeter(p), .area(a), .x_min(xa), .x_max(xb), .y_min(ya), .y_max(yb),
         .busy_out(bz), .valid_out(vo));
      assign o_perim[2+m] = 64'(p);
      assign o_area[2+m]  = 64'(a);
      assign o_x0[2+m]    = 64'(xa);
      assign o_x1[2+m]    = 64'(xb);
      assign o_y0[2+m]    = 64'(ya);
      assign o_y1[2+m]    = 64'(yb);
      assign o_busy[2+m]  = bz;
      assign o_valid[2+m] = vo;
   end

   int total = 0;
   int bad   = 0;
   bit img [0:BH-1][0:BW-1];
   int e_area, e_x0, e_x1, e_y0, e_y1;
   int e_per[2];

   function automatic int gw(input int g);
      return (g == 0) ? SW : BW;
   endfunction

   function automatic int gh(input int g);
      return (g == 0) ? SH : BH;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_exp(input int a, input int p0, input int p1,
                          input int x0, input int x1, input int y0, input int y1);
      e_area   = a;
      e_per[0] = p0;
      e_per[1] = p1;
      e_x0 = x0; e_x1 = x1; e_y0 = y0; e_y1 = y1;
   endtask

   task automatic clear_img();
      foreach (img[i, j]) img[i][j] = 1'b0;
   endtask

   task automatic rect(input int x0, input int x1, input int y0, input int y1);
      for (int yy = y0; yy <= y1; yy++)
         for (int xx = x0; xx <= x1; xx++)
            img[yy][xx] = 1'b1;
   endtask

   task automatic rand_img(input int g, input int pct);
      clear_img();
      for (int yy = 0; yy < gh(g); yy++)
         for (int xx = 0; xx < gw(g); xx++)
            img[yy][xx] = ($urandom_range(99) < pct);
   endtask

   // Reference: every foreground pixel looks at its four neighbours, with
   // anything outside the frame treated as background.
   task automatic model(input int g);
      int w, h, nb;
      bit first;
      w = gw(g);
      h = gh(g);
      first = 1'b1;
      set_exp(0, 0, 0, 0, 0, 0, 0);
      for (int yy = 0; yy < h; yy++) begin
         for (int xx = 0; xx < w; xx++) begin
            if (img[yy][xx]) begin
               e_area++;
               if (first) begin
                  e_x0 = xx; e_x1 = xx; e_y0 = yy; e_y1 = yy;
                  first = 1'b0;
               end else begin
                  if (xx < e_x0) e_x0 = xx;
                  if (xx > e_x1) e_x1 = xx;
                  if (yy < e_y0) e_y0 = yy;
                  if (yy > e_y1) e_y1 = yy;
               end
               nb = 0;
               if (yy == 0     || !img[yy-1][xx]) nb++;
               if (yy == h - 1 || !img[yy+1][xx]) nb++;
               if (xx == 0     || !img[yy][xx-1]) nb++;
               if (xx == w - 1 || !img[yy][xx+1]) nb++;
               if (nb > 0) e_per[0]++;
               e_per[1] += nb;
            end
         end
      end
   endtask

   task automatic cyc(input int g, input bit v, input int xx, input int yy, input bit mk);
      @(negedge clk);
      vld  = 2'b00;
      fd   = 2'b00;
      if (v) vld[g] = 1'b1;
      x    = 11'(xx);
      y    = 10'(yy);
      mask = mk;
   endtask

   task automatic send_rows(input int g, input int nrows, input int gap, input bit oob);
      int ng;
      for (int yy = 0; yy < nrows; yy++) begin
         for (int xx = 0; xx < gw(g); xx++) begin
            ng = ($urandom_range(99) < gap) ? int'($urandom_range(3, 1)) : 0;
            repeat (ng) cyc(g, 1'b0, $urandom_range(2047), $urandom_range(1023), 1'b1);
            if (oob && $urandom_range(15) == 0) cyc(g, 1'b1, gw(g) + $urandom_range(30), yy, 1'b1);
            if (oob && $urandom_range(31) == 0) cyc(g, 1'b1, xx, gh(g) + $urandom_range(30), 1'b1);
            cyc(g, 1'b1, xx, yy, img[yy][xx]);
         end
      end
   endtask

   task automatic chk_res(input string tag, input int i, input int m);
      chk($sformatf("%s.m%0d.area", tag, m),  o_area[i],  64'(e_area));
      chk($sformatf("%s.m%0d.perim", tag, m), o_perim[i], 64'(e_per[m]));
      chk($sformatf("%s.m%0d.xmin", tag, m),  o_x0[i],    64'(e_x0));
      chk($sformatf("%s.m%0d.xmax", tag, m),  o_x1[i],    64'(e_x1));
      chk($sformatf("%s.m%0d.ymin", tag, m),  o_y0[i],    64'(e_y0));
      chk($sformatf("%s.m%0d.ymax", tag, m),  o_y1[i],    64'(e_y1));
   endtask

   // Pulse frame_done and watch busy/valid for WIDTH+4 cycles afterwards.
   task automatic flush_check(input int g, input string tag, input bit inject);
      int w;
      int nb[2], nv[2], vk[2];
      w  = gw(g);
      nb = '{0, 0};
      nv = '{0, 0};
      vk = '{0, 0};
      @(negedge clk);
      vld   = 2'b00;
      fd    = 2'b00;
      fd[g] = 1'b1;
      for (int k = 1; k <= w + 4; k++) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            if (o_busy[2*g+m]) nb[m]++;
            if (o_valid[2*g+m]) begin
               nv[m]++;
               vk[m] = k;
               chk_res(tag, 2*g + m, m);
            end
         end
         vld = 2'b00;
         fd  = 2'b00;
         if (inject && k <= w) begin
            vld[g] = 1'b1;
            x      = 11'($urandom_range(w - 1));
            y      = 10'($urandom_range(gh(g) - 1));
            mask   = 1'b1;
            fd[g]  = 1'($urandom_range(1));
         end
      end
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s.m%0d.busy_cycles", tag, m), 64'(nb[m]), 64'(w));
         chk($sformatf("%s.m%0d.valid_latency", tag, m), 64'(vk[m]), 64'(w + 1));
         chk($sformatf("%s.m%0d.valid_count", tag, m), 64'(nv[m]), 64'd1);
         chk_res({tag, ".hold"}, 2*g + m, m);
      end
   endtask

   task automatic reset_mid_flush(input int g, input string tag);
      int nv[2], nb[2];
      nv = '{0, 0};
      nb = '{0, 0};
      @(negedge clk);
      vld   = 2'b00;
      fd    = 2'b00;
      fd[g] = 1'b1;
      @(negedge clk);
      fd = 2'b00;
      repeat (3) @(negedge clk);
      for (int m = 0; m < 2; m++)
         chk($sformatf("%s.m%0d.busy_before", tag, m), 64'(o_busy[2*g+m]), 64'd1);
      rst = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s.m%0d.area", tag, m),  o_area[2*g+m],  64'd0);
         chk($sformatf("%s.m%0d.perim", tag, m), o_perim[2*g+m], 64'd0);
         chk($sformatf("%s.m%0d.xmax", tag, m),  o_x1[2*g+m],    64'd0);
         chk($sformatf("%s.m%0d.ymax", tag, m),  o_y1[2*g+m],    64'd0);
         chk($sformatf("%s.m%0d.busy", tag, m),  64'(o_busy[2*g+m]), 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < gw(g) + 4; k++) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            if (o_valid[2*g+m]) nv[m]++;
            if (o_busy[2*g+m])  nb[m]++;
         end
      end
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s.m%0d.no_valid", tag, m), 64'(nv[m]), 64'd0);
         chk($sformatf("%s.m%0d.no_busy", tag, m),  64'(nb[m]), 64'd0);
      end
   endtask

   initial begin
      rst  = 1'b1;
      vld  = 2'b00;
      fd   = 2'b00;
      x    = '0;
      y    = '0;
      mask = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset.i%0d.area", i),  o_area[i],  64'd0);
         chk($sformatf("reset.i%0d.perim", i), o_perim[i], 64'd0);
         chk($sformatf("reset.i%0d.xmax", i),  o_x1[i],    64'd0);
         chk($sformatf("reset.i%0d.busy", i),  64'(o_busy[i]),  64'd0);
         chk($sformatf("reset.i%0d.valid", i), 64'(o_valid[i]), 64'd0);
      end
      rst = 1'b0;

      // 8x4 fully foreground
      clear_img();
      rect(0, SW - 1, 0, SH - 1);
      set_exp(32, 20, 24, 0, 7, 0, 3);
      send_rows(0, SH, 0, 1'b0);
      flush_check(0, "s_full", 1'b0);

      // 8x4 random frames with gaps and out-of-frame pixels
      for (int f = 0; f < 10; f++) begin
         rand_img(0, $urandom_range(90, 20));
         model(0);
         send_rows(0, SH, 30, 1'b1);
         flush_check(0, $sformatf("s_rnd%0d", f), f[0]);
      end

      // single foreground pixel
      clear_img();
      img[5][5] = 1'b1;
      set_exp(1, 1, 4, 5, 5, 5, 5);
      send_rows(1, BH, 20, 1'b0);
      flush_check(1, "b_dot", 1'b0);

      // 3x3 block
      clear_img();
      rect(10, 12, 20, 22);
      set_exp(9, 8, 12, 10, 12, 20, 22);
      send_rows(1, BH, 25, 1'b1);
      flush_check(1, "b_block", 1'b0);

      // all background, gapped stream
      clear_img();
      set_exp(0, 0, 0, 0, 0, 0, 0);
      send_rows(1, BH, 40, 1'b0);
      flush_check(1, "b_empty", 1'b0);

      // bottom-row object, pixels and frame_done injected while busy
      clear_img();
      rect(0, 3, BH - 1, BH - 1);
      set_exp(4, 4, 10, 0, 3, BH - 1, BH - 1);
      send_rows(1, BH, 10, 1'b0);
      flush_check(1, "b_bottom", 1'b1);

      // restart: a partial frame abandoned by a new pixel (0,0)
      rand_img(1, 60);
      send_rows(1, 5, 10, 1'b0);
      rand_img(1, 40);
      model(1);
      send_rows(1, BH, 10, 1'b0);
      flush_check(1, "b_restart", 1'b0);

      // random frames
      for (int f = 0; f < 5; f++) begin
         rand_img(1, $urandom_range(85, 5));
         model(1);
         send_rows(1, BH, 20, 1'b1);
         flush_check(1, $sformatf("b_rnd%0d", f), f[0]);
      end

      // reset during flush, then a clean frame
      rand_img(1, 50);
      send_rows(1, BH, 5, 1'b0);
      reset_mid_flush(1, "b_rst");
      rand_img(1, 35);
      model(1);
      send_rows(1, BH, 15, 1'b0);
      flush_check(1, "b_after_rst", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
